flash_ssram_bus_ctrl: RTL
=========================

Name: flash_ssram_bus_ctrl

Overview:
Controller and arbiter for the board's shared flash/SSRAM address/data bus. Two client ports (16-bit flash, 32-bit SSRAM) request single-word accesses. The block grants the bus round-robin, sequences flash asynchronous timing with programmable cycle counts, and sequences synchronous SSRAM accesses. It sits between on-chip masters and the top-level pins; tristate buffers stay at top level, driven from bus_d_out/bus_d_oe.

Parameters:
FL_SETUP_CYC, 2, cycles with cs_n low and address stable before the flash strobe (>=1)
FL_ACCESS_CYC, 8, cycles with flash oe_n/wr_n low (>=1)
FL_HOLD_CYC, 2, cycles with strobe high and cs_n/address/data held (>=1)
SR_AW, 20, SSRAM word-address width (<=26)
SR_RD_LAT, 2, SSRAM clocks from the ADSC edge to valid read data (1..3)
TURN_CYC, 1, bus-idle cycles after any read before the next grant (>=0)
RST_PULSE_CYC, 64, flash_reset_n low time (optional feature only)

Ports:
osc_clk  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
fl_req  in  1  flash request; held with fl_we/fl_addr/fl_wdata stable until fl_ack
fl_we  in  1  1=write, 0=read
fl_addr  in  26  flash word address
fl_wdata  in  16  write data
fl_rdata  out  16  read data, valid in fl_ack cycle
fl_ack  out  1  one-cycle completion pulse
sr_req  in  1  SSRAM request; same hold rule
sr_we  in  1  1=write
sr_be  in  4  byte enables, active high
sr_addr  in  SR_AW  SSRAM word address
sr_wdata  in  32  write data
sr_rdata  out  32  read data, valid in sr_ack cycle
sr_ack  out  1  one-cycle completion pulse
bus_a  out  26  shared address; top maps [23:0], a24, a25
bus_d_out  out  32  data to drive
bus_d_oe  out  1  tristate enable for bus_d_out
bus_d_in  in  32  pin data
flash_cs_n, flash_oe_n, flash_wr_n  out  1 each  flash strobes
ssram_ce_n, ssram_adsc_n, ssram_oe_n, ssram_bwe_n  out  1 each  SSRAM strobes
ssram_bw_n  out  4  SSRAM byte-write enables
flash_reset_n  out  1  flash reset; constant 1 unless the feature is enabled

Behaviour:
- All outputs are registered. The clock is osc_clk; reset is reset_n, asynchronous and active-low.
- Reset values: all *_n strobes 1, flash_reset_n 1 (0 with the feature), bus_d_oe 0, bus_a 0, bus_d_out 0, acks 0, rdata 0, last_grant = SSRAM.
- Reset asserted mid-transaction: strobes deassert and bus_d_oe drops immediately. No ack is issued.
- FSM states: IDLE, FL_SETUP, FL_ACCESS, FL_HOLD, SR_ADDR, SR_WR, SR_RD, DONE, TURN.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the device not in last_grant. last_grant updates on each grant.
  - No preemption.
- Flash transaction, req seen in cycle 0:
  - FL_SETUP for cycles 1..S: cs_n=0; bus_a=fl_addr; on write, bus_d_out[15:0]=fl_wdata, [31:16]=0, bus_d_oe=1.
  - FL_ACCESS for the next A cycles: oe_n=0 (read) or wr_n=0 (write). Read data is captured from bus_d_in[15:0] at the clock edge ending the last access cycle.
  - FL_HOLD for the next H cycles: strobe high; cs_n, address and write data held.
  - DONE: fl_ack=1, all strobes high, bus_d_oe=0.
  - Defaults: ack in cycle 13 (1+S+A+H).
- SSRAM write: SR_ADDR (cycle 1) ce_n=0, adsc_n=0, bus_a=zero-extended sr_addr. SR_WR (cycle 2) ce_n=0, bwe_n=0, bw_n=~sr_be, data driven with bus_d_oe=1. DONE (cycle 3) sr_ack.
- SSRAM read: SR_ADDR (cycle 1) ce_n=0, adsc_n=0. SR_RD for SR_RD_LAT cycles with oe_n=0; bus_d_in is captured at the edge ending SR_RD. DONE at cycle 2+SR_RD_LAT (default 4).
- After DONE of any read, TURN holds for TURN_CYC cycles with all outputs idle, then IDLE. After a write, DONE goes directly to IDLE.
- A grant is never issued in DONE or TURN. Minimum grant-to-grant spacing is one DONE cycle.
- Dropping req before ack is a protocol violation. The transaction still completes and acks.
- A request held in the ack cycle is treated as a new request.
- Counters are sized $clog2(max+1); no wrap occurs within a state.

Optional Feature:
FSB_FLASH_RESET_EN:
- Defined: after reset release, flash_reset_n is driven 0 for RST_PULSE_CYC cycles, then 1. Flash grants are blocked until flash_reset_n has been 1 for 4 cycles. SSRAM grants proceed meanwhile.
- Undefined: flash_reset_n is tied 1 and flash grants are available immediately.

Decomposition:
- Package flash_ssram_bus_pkg: FSM state enum, bus width constants (26 address, 32 data, 16 flash data), device id enum for last_grant.
- Sub-module fsb_cycle_counter: loadable down-counter with zero flag, reused for the setup/access/hold/latency/turnaround/reset-pulse counts.

Test Plan:
- Flash read, fl_addr=0x0123456, bus_d_in[15:0]=0xBEEF during access → cs_n low cycles 1-12, oe_n low cycles 3-10, fl_ack in cycle 13, fl_rdata=0xBEEF.
- SSRAM write, sr_addr=0x00ABC, sr_be=4'b0101, wdata=0xCAFEF00D → adsc_n low in cycle 1; bwe_n low, bw_n=4'b1010, bus_d_oe=1 in cycle 2; sr_ack in cycle 3.
- SSRAM read, SR_RD_LAT=2, bus_d_in=0x12345678 → oe_n low cycles 2-3, sr_ack in cycle 4 with sr_rdata=0x12345678; one TURN cycle, then IDLE.
- fl_req and sr_req asserted together and held continuously → grants alternate flash, SSRAM, flash, ...; no state overlap; turnaround inserted after each read.
- reset_n pulled low in cycle 5 of a flash write → all strobes 1 and bus_d_oe 0 immediately; no fl_ack; a new request after release starts from IDLE.
- With FSB_FLASH_RESET_EN defined, fl_req held from reset release → flash_reset_n low for 64 cycles; first flash grant no earlier than 4 cycles after it rises; an sr_req issued at cycle 10 completes at cycle 13.

Source files
------------

// File: rtl/flash_ssram_bus_pkg.sv
// Shared types and constants for the flash/SSRAM shared-bus controller:
// FSM state encoding, bus widths and the device id used for round-robin.
package flash_ssram_bus_pkg;

  localparam int ADDR_W    = 26;
  localparam int DATA_W    = 32;
  localparam int FL_DATA_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FL_SETUP,
    ST_FL_ACCESS,
    ST_FL_HOLD,
    ST_SR_ADDR,
    ST_SR_WR,
    ST_SR_RD,
    ST_DONE,
    ST_TURN
  } state_e;

  typedef enum logic {
    DEV_FLASH = 1'b0,
    DEV_SSRAM = 1'b1
  } dev_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fsb_cycle_counter.sv
// Loadable down-counter with zero flag. Counts down to zero and sticks there;
// a load overrides the decrement. Used for every programmable phase length.
module fsb_cycle_counter #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; otherwise decrement until zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/flash_ssram_bus_ctrl.sv
// Arbiter and cycle sequencer for the shared flash/SSRAM address/data bus.
// Round-robin grant between a 16-bit async flash client and a 32-bit sync
// SSRAM client; all pin-side outputs are registered.
// Optional feature macro: FSB_FLASH_RESET_EN (flash reset pulse after reset
// release, flash grants held off until the flash has been out of reset 4 cycles).
module flash_ssram_bus_ctrl
  import flash_ssram_bus_pkg::*;
#(
  parameter int FL_SETUP_CYC  = 2,
  parameter int FL_ACCESS_CYC = 8,
  parameter int FL_HOLD_CYC   = 2,
  parameter int SR_AW         = 20,
  parameter int SR_RD_LAT     = 2,
  parameter int TURN_CYC      = 1
`ifdef FSB_FLASH_RESET_EN
  , parameter int RST_PULSE_CYC = 64
`endif
) (
  input  logic                 osc_clk,
  input  logic                 reset_n,
  input  logic                 fl_req,
  input  logic                 fl_we,
  input  logic [ADDR_W-1:0]    fl_addr,
  input  logic [FL_DATA_W-1:0] fl_wdata,
  output logic [FL_DATA_W-1:0] fl_rdata,
  output logic                 fl_ack,
  input  logic                 sr_req,
  input  logic                 sr_we,
  input  logic [3:0]           sr_be,
  input  logic [SR_AW-1:0]     sr_addr,
  input  logic [DATA_W-1:0]    sr_wdata,
  output logic [DATA_W-1:0]    sr_rdata,
  output logic                 sr_ack,
  output logic [ADDR_W-1:0]    bus_a,
  output logic [DATA_W-1:0]    bus_d_out,
  output logic                 bus_d_oe,
  input  logic [DATA_W-1:0]    bus_d_in,
  output logic                 flash_cs_n,
  output logic                 flash_oe_n,
  output logic                 flash_wr_n,
  output logic                 ssram_ce_n,
  output logic                 ssram_adsc_n,
  output logic                 ssram_oe_n,
  output logic                 ssram_bwe_n,
  output logic [3:0]           ssram_bw_n,
  output logic                 flash_reset_n
);

  // Counter holds (phase length - 1); width covers the longest phase.
  localparam int CNT_MAX   = max_int(max_int(max_int(FL_SETUP_CYC - 1, FL_ACCESS_CYC - 1),
                                             max_int(FL_HOLD_CYC - 1, SR_RD_LAT - 1)),
                                     max_int(TURN_CYC, 1));
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int TURN_LOAD = (TURN_CYC > 0) ? TURN_CYC - 1 : 0;

  state_e          state;
  dev_e            last_grant;
  logic            cur_we;
  logic            cnt_load;
  logic [CW-1:0]   cnt_val;
  logic            cnt_zero;
  logic            fl_ready;
  logic            fl_pending;
  logic            grant_fl;
  logic            grant_sr;

`ifdef FSB_FLASH_RESET_EN
  localparam int RW = $clog2(max_int(RST_PULSE_CYC, 4));
  logic rst_zero;
  logic rst_load;

  // First the pulse length, then a reload of 3 for the 4-cycle settle window.
  assign rst_load = !flash_reset_n && rst_zero;

  fsb_cycle_counter #(.W(RW), .RST_VAL(RW'(RST_PULSE_CYC - 1))) u_rst_cnt (
    .clk      (osc_clk),
    .rst_n    (reset_n),
    .load     (rst_load),
    .load_val (RW'(3)),
    .zero     (rst_zero)
  );

  // Release the flash after the pulse, then open flash grants after settling.
  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_reset_n <= 1'b0;
      fl_ready      <= 1'b0;
    end else if (!flash_reset_n && rst_zero) begin
      flash_reset_n <= 1'b1;
    end else if (flash_reset_n && rst_zero) begin
      fl_ready      <= 1'b1;
    end
  end
`else
  assign flash_reset_n = 1'b1;
  assign fl_ready      = 1'b1;
`endif

  // Round-robin: a lone request wins, a tie goes to the device not granted last.
  assign fl_pending = fl_req && fl_ready;
  assign grant_fl   = fl_pending && (!sr_req || last_grant == DEV_SSRAM);
  assign grant_sr   = sr_req && (!fl_pending || last_grant == DEV_FLASH);

  // Phase counter reload on each timed-state entry.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_IDLE:      begin cnt_load = 1'b1; cnt_val = CW'(FL_SETUP_CYC - 1); end
      ST_FL_SETUP:  if (cnt_zero) begin cnt_load = 1'b1; cnt_val = CW'(FL_ACCESS_CYC - 1); end
      ST_FL_ACCESS: if (cnt_zero) begin cnt_load = 1'b1; cnt_val = CW'(FL_HOLD_CYC - 1); end
      ST_SR_ADDR:   begin cnt_load = 1'b1; cnt_val = CW'(SR_RD_LAT - 1); end
      ST_DONE:      begin cnt_load = 1'b1; cnt_val = CW'(TURN_LOAD); end
      default:      ;
    endcase
  end

  fsb_cycle_counter #(.W(CW), .RST_VAL(CW'(0))) u_phase_cnt (
    .clk      (osc_clk),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Sequencer: outputs are set on the transition into each state so they are
  // registered and valid for the whole state.
  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      last_grant   <= DEV_SSRAM;
      cur_we       <= 1'b0;
      flash_cs_n   <= 1'b1;
      flash_oe_n   <= 1'b1;
      flash_wr_n   <= 1'b1;
      ssram_ce_n   <= 1'b1;
      ssram_adsc_n <= 1'b1;
      ssram_oe_n   <= 1'b1;
      ssram_bwe_n  <= 1'b1;
      ssram_bw_n   <= 4'hF;
      bus_a        <= '0;
      bus_d_out    <= '0;
      bus_d_oe     <= 1'b0;
      fl_ack       <= 1'b0;
      sr_ack       <= 1'b0;
      fl_rdata     <= '0;
      sr_rdata     <= '0;
    end else begin
      fl_ack <= 1'b0;
      sr_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_fl) begin
            state      <= ST_FL_SETUP;
            last_grant <= DEV_FLASH;
            cur_we     <= fl_we;
            flash_cs_n <= 1'b0;
            bus_a      <= fl_addr;
            bus_d_out  <= {16'h0000, fl_wdata};
            bus_d_oe   <= fl_we;
          end else if (grant_sr) begin
            state        <= ST_SR_ADDR;
            last_grant   <= DEV_SSRAM;
            cur_we       <= sr_we;
            ssram_ce_n   <= 1'b0;
            ssram_adsc_n <= 1'b0;
            bus_a        <= ADDR_W'(sr_addr);
          end
        end
        ST_FL_SETUP: begin
          if (cnt_zero) begin
            state <= ST_FL_ACCESS;
            if (cur_we) flash_wr_n <= 1'b0;
            else        flash_oe_n <= 1'b0;
          end
        end
        ST_FL_ACCESS: begin
          if (cnt_zero) begin
            state      <= ST_FL_HOLD;
            flash_oe_n <= 1'b1;
            flash_wr_n <= 1'b1;
            if (!cur_we) fl_rdata <= bus_d_in[FL_DATA_W-1:0];
          end
        end
        ST_FL_HOLD: begin
          if (cnt_zero) begin
            state      <= ST_DONE;
            flash_cs_n <= 1'b1;
            bus_d_oe   <= 1'b0;
            fl_ack     <= 1'b1;
          end
        end
        ST_SR_ADDR: begin
          ssram_adsc_n <= 1'b1;
          if (cur_we) begin
            state       <= ST_SR_WR;
            ssram_bwe_n <= 1'b0;
            ssram_bw_n  <= ~sr_be;
            bus_d_out   <= sr_wdata;
            bus_d_oe    <= 1'b1;
          end else begin
            state      <= ST_SR_RD;
            ssram_oe_n <= 1'b0;
          end
        end
        ST_SR_WR: begin
          state       <= ST_DONE;
          ssram_ce_n  <= 1'b1;
          ssram_bwe_n <= 1'b1;
          ssram_bw_n  <= 4'hF;
          bus_d_oe    <= 1'b0;
          sr_ack      <= 1'b1;
        end
        ST_SR_RD: begin
          if (cnt_zero) begin
            state      <= ST_DONE;
            ssram_ce_n <= 1'b1;
            ssram_oe_n <= 1'b1;
            sr_rdata   <= bus_d_in;
            sr_ack     <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!cur_we && TURN_CYC > 0) state <= ST_TURN;
          else                         state <= ST_IDLE;
        end
        ST_TURN: begin
          if (cnt_zero) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
